keccak_xor_io: RTL and testbench

Sponge absorb stage of the SHA-3/Keccak core: merges the next message block (`Xin`) with the current permutation state (`Xout`) lane-by-lane. It sits between the padding/block loader and the Keccak-f round logic. It produces a registered 5×5×WIDTH state `D` that feeds the permutation.

---
 rtl/keccak_pkg.sv | 17 +
 rtl/keccak_lane_xor.sv | 18 +
 rtl/keccak_xor_io.sv | 51 +++++
 tb/tb_keccak_xor_io.sv | 130 +++++++++++++
 4 files changed

// File: rtl/keccak_pkg.sv
// Shared types and constants for the Keccak datapath.
//   WIDTH     : default lane width in bits
//   NUM_LANES : lanes per state (5x5)
//   lane_t    : one lane
//   state_t   : full state, indexed [x][y], lane number x+5y
package keccak_pkg;
  localparam int WIDTH     = 64;
  localparam int NUM_LANES = 25;

  typedef logic [WIDTH-1:0] lane_t;
  typedef lane_t [0:4][0:4] state_t;

  // Linear lane number for lane (x, y).
  function automatic int lane_idx(input int x, input int y);
    return x + 5 * y;
  endfunction
endpackage

// File: rtl/keccak_lane_xor.sv
// One lane of the absorb merge.
//   a   : message lane (Xin)
//   b   : state lane (Xout)
//   sel : 1 = absorb (a ^ b), 0 = load (a)
//   y   : merged lane, combinational
module keccak_lane_xor
  import keccak_pkg::*;
#(
  parameter int W = keccak_pkg::WIDTH
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         sel,
  output logic [W-1:0] y
);
  // Gating b keeps the lane purely bitwise: bit i of y sees only bit i of a and b.
  assign y = a ^ (b & {W{sel}});
endmodule

// File: rtl/keccak_xor_io.sv
// Sponge absorb stage: merges the next message block into the current
// permutation state and registers the result for Keccak-f.
//   clk, rst_n : rising-edge clock, async active-low reset
//   Xin        : message block, [x][y] lanes
//   Xout       : current state from the previous permutation
//   X          : 1 = XOR block into state, 0 = load block (first block)
//   in_valid   : Xin/Xout/X valid this cycle
//   D          : registered merged state
//   out_valid  : D was updated on the last edge
module keccak_xor_io
  import keccak_pkg::*;
#(
  parameter int WIDTH = keccak_pkg::WIDTH
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [0:4][0:4][WIDTH-1:0]    Xin,
  input  logic [0:4][0:4][WIDTH-1:0]    Xout,
  input  logic                          X,
  input  logic                          in_valid,
  output logic [0:4][0:4][WIDTH-1:0]    D,
  output logic                          out_valid
);
  logic [0:4][0:4][WIDTH-1:0] nxt;

  // All 25 lanes are identical; rate/capacity split is the loader's concern.
  for (genvar gx = 0; gx < 5; gx++) begin : g_x
    for (genvar gy = 0; gy < 5; gy++) begin : g_y
      keccak_lane_xor #(.W(WIDTH)) u_lane (
        .a   (Xin[gx][gy]),
        .b   (Xout[gx][gy]),
        .sel (X),
        .y   (nxt[gx][gy])
      );
    end
  end

  // D holds when in_valid is low so the consumer can re-read it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      D <= '0;
    end else if (in_valid) begin
      D <= nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) out_valid <= 1'b0;
    else        out_valid <= in_valid;
  end
endmodule

// File: tb/tb_keccak_xor_io.sv
// Self-checking bench for keccak_xor_io (WIDTH=64) using a scoreboard queue.
module tb_keccak_xor_io;
  typedef logic [0:4][0:4][63:0] st_t;
  typedef struct { st_t d; logic v; } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  st_t  Xin = '0, Xout = '0;
  logic X = 1'b0, in_valid = 1'b0;
  st_t  D;
  logic out_valid;

  int   n_vec = 0, n_err = 0;
  exp_t sb[$];
  st_t  mdl = '0;

  keccak_xor_io #(.WIDTH(64)) dut (
    .clk(clk), .rst_n(rst_n), .Xin(Xin), .Xout(Xout), .X(X),
    .in_valid(in_valid), .D(D), .out_valid(out_valid)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [1599:0] got, input logic [1599:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic st_t rnd_st();
    st_t s;
    for (int x = 0; x < 5; x++)
      for (int y = 0; y < 5; y++)
        s[x][y] = {$urandom, $urandom};
    return s;
  endfunction

  // Drive one cycle; push the expected outcome, then pop and compare after the edge.
  task automatic step(input string tag, input st_t xi, input st_t xo, input logic xs,
                      input logic vi, input logic use_ex, input st_t ex);
    exp_t e;
    @(negedge clk);
    Xin = xi; Xout = xo; X = xs; in_valid = vi;
    if (vi) begin
      if (use_ex) mdl = ex;
      else begin
        for (int x = 0; x < 5; x++)
          for (int y = 0; y < 5; y++)
            mdl[x][y] = xs ? (xi[x][y] ^ xo[x][y]) : xi[x][y];
      end
    end
    sb.push_back('{d: mdl, v: vi});
    @(posedge clk);
    #1;
    e = sb.pop_front();
    chk({tag, ".d"}, D, e.d);
    chk({tag, ".v"}, {1599'b0, out_valid}, {1599'b0, e.v});
  endtask

  st_t a3_blk, xo3, ex3, z;

  initial begin
    z = '0;
    // 1: reset holds everything at zero regardless of inputs and clock
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      Xin = rnd_st(); Xout = rnd_st(); X = 1'($urandom); in_valid = 1'b1;
      @(posedge clk); #2;
      chk("rst.d", D, '0);
      chk("rst.v", {1599'b0, out_valid}, '0);
    end
    // Release right after the edge that saw in_valid=1: that edge must not capture.
    #3; rst_n = 1'b1;
    #1;
    chk("rel.d", D, '0);
    chk("rel.v", {1599'b0, out_valid}, '0);

    // 2: pass-through
    a3_blk = '0;
    for (int n = 0; n < 17; n++) a3_blk[n % 5][n / 5] = 64'hA3A3A3A3A3A3A3A3;
    step("pass", a3_blk, rnd_st(), 1'b0, 1'b1, 1'b1, a3_blk);

    // 3: absorb with hand-derived expected state
    xo3 = '0;
    for (int x = 0; x < 5; x++) xo3[x][0] = 64'hA3A3A3A3A3A3A3A3;
    for (int x = 0; x < 3; x++) xo3[x][1] = 64'hA3A3A3A3A3A3A3A3;
    xo3[3][1] = 64'h00000000000000C3;
    xo3[1][3] = 64'h8000000000000000;
    ex3 = '0;
    ex3[3][1] = 64'hA3A3A3A3A3A3A360;
    ex3[4][1] = 64'hA3A3A3A3A3A3A3A3;
    for (int x = 0; x < 5; x++) ex3[x][2] = 64'hA3A3A3A3A3A3A3A3;
    ex3[0][3] = 64'hA3A3A3A3A3A3A3A3;
    ex3[1][3] = 64'h23A3A3A3A3A3A3A3;
    step("absorb", a3_blk, xo3, 1'b1, 1'b1, 1'b1, ex3);

    // 4: hold while in_valid low, inputs changing
    step("hold0", rnd_st(), rnd_st(), 1'b1, 1'b0, 1'b1, ex3);
    step("hold1", rnd_st(), rnd_st(), 1'b0, 1'b0, 1'b1, ex3);
    chk("hold.abs", D, ex3);

    // 5: back-to-back X=1/0/1
    step("b2b0", rnd_st(), rnd_st(), 1'b1, 1'b1, 1'b0, z);
    step("b2b1", rnd_st(), rnd_st(), 1'b0, 1'b1, 1'b0, z);
    step("b2b2", rnd_st(), rnd_st(), 1'b1, 1'b1, 1'b0, z);

    // 6: mid-cycle reset while out_valid=1 clears without a clock edge
    #2; rst_n = 1'b0;
    #1;
    chk("mrst.d", D, '0);
    chk("mrst.v", {1599'b0, out_valid}, '0);
    mdl = '0;
    @(negedge clk); in_valid = 1'b0;
    rst_n = 1'b1;
    // First capture after reset behaves normally.
    step("post", rnd_st(), rnd_st(), 1'b1, 1'b1, 1'b0, z);
    step("postidle", rnd_st(), rnd_st(), 1'b0, 1'b0, 1'b0, z);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1);
  end
endmodule
